arm_data_mem: RTL and testbench

//   Data-side responder for the single-cycle arm core. It receives the core's ALUResult
//   (address), WriteData and MemWrite, and returns ReadData in the same cycle.

---
 rtl/arm_data_mem_if.sv | 21 ++
 rtl/arm_data_mem.sv | 94 +++++++++
 tb/tb_arm_data_mem.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/arm_data_mem_if.sv
// Data-side bus between the arm core and arm_data_mem, plus the console TX stream.
// master = core/consumer side, slave = the memory responder.
interface arm_data_mem_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, tx_data, tx_valid
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, tx_data, tx_valid
  );
endinterface

// File: rtl/arm_data_mem.sv
// Word RAM plus MMIO window (TX FIFO, STATUS, CYCLES) for the single-cycle arm core.
// Optional ARM_DMEM_BOUNDS_EN: flag and suppress accesses between RAM top and MMIO_BASE.
module arm_data_mem #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input logic          clk,
  input logic          reset,
  arm_data_mem_if.slave bus
);
  localparam int unsigned   AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned   PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW        = PW + 1;
  localparam logic [31:0]   RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  logic [31:0]   r_ram  [DEPTH_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_cycles;
  logic          r_ovf, r_bad;

  logic [31:0] w_addr, w_status, w_rdata;
  logic        w_is_tx, w_is_status, w_is_cycles, w_ram_sel, w_bad;
  logic        w_full, w_empty, w_push, w_pop, w_push_ok, w_ovf_set, w_status_wr;

  assign w_addr      = bus.ALUResult & ~32'h3;
  assign w_is_tx     = (w_addr == MMIO_BASE);
  assign w_is_status = (w_addr == MMIO_BASE + 32'd4);
  assign w_is_cycles = (w_addr == MMIO_BASE + 32'd8);

`ifdef ARM_DMEM_BOUNDS_EN
  assign w_ram_sel = (w_addr < RAM_BYTES);
  assign w_bad     = !w_ram_sel && (w_addr < MMIO_BASE);
`else
  // Everything below the MMIO window aliases into RAM via the low index bits.
  assign w_ram_sel = (w_addr < MMIO_BASE) || (w_addr < RAM_BYTES);
  assign w_bad     = 1'b0;
`endif

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_pop       = !w_empty && bus.tx_ready;
  assign w_push      = bus.MemWrite && w_is_tx;
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_ovf_set   = w_push && w_full && !w_pop;
  assign w_status_wr = bus.MemWrite && w_is_status;

  assign w_status = {20'd0, r_bad, r_ovf, w_empty, w_full, 8'(r_count)};

  always_comb begin
    w_rdata = 32'd0;
    if (w_ram_sel)        w_rdata = r_ram[bus.ALUResult[AW+1:2]];
    else if (w_is_status) w_rdata = w_status;
    else if (w_is_cycles) w_rdata = r_cycles;
  end

  assign bus.ReadData = w_rdata;
  assign bus.tx_valid = !w_empty;
  assign bus.tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr];

  // Storage arrays are not reset; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && w_ram_sel) r_ram[bus.ALUResult[AW+1:2]] <= bus.WriteData;
    if (w_push_ok)                 r_fifo[r_wptr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_cycles <= 32'd0;
      r_ovf    <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new event in the same cycle as the W1C write wins.
      if (w_ovf_set)                             r_ovf <= 1'b1;
      else if (w_status_wr && bus.WriteData[10]) r_ovf <= 1'b0;
      if (bus.MemWrite && w_bad)                 r_bad <= 1'b1;
      else if (w_status_wr && bus.WriteData[11]) r_bad <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arm_data_mem.sv
// Directed self-checking bench for arm_data_mem: RAM, TX FIFO, STATUS, CYCLES, reset.
module tb_arm_data_mem;
  localparam logic [31:0] TXA = 32'hFFFF0000;
  localparam logic [31:0] STA = 32'hFFFF0004;
  localparam logic [31:0] CYA = 32'hFFFF0008;

  logic clk, reset;
  int   n_checks, n_fail;
  logic [31:0] v0, v1;

  arm_data_mem_if bus ();

  arm_data_mem dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at a falling edge, commit at the rising edge, return at the next falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.ALUResult = a;
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    @(negedge clk);
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.MemWrite  = 1'b0;
    bus.ALUResult = a;
    #1;
    d = bus.ReadData;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.MemWrite = 1'b0; bus.ALUResult = 32'd0; bus.WriteData = 32'd0; bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    rd(STA, v0); check("rst_status", v0, 32'h200);
    rd(CYA, v0); check("rst_cycles", v0, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    rd(CYA, v0); check("cycles_first", v0, 32'd1);

    // RAM store/load and read-before-write in the store cycle
    wr(32'h10, 32'h11111111);
    bus.ALUResult = 32'h10; bus.WriteData = 32'hAABBCCDD; bus.MemWrite = 1'b1;
    #1 check("ram_old_during_store", bus.ReadData, 32'h11111111);
    @(negedge clk); bus.MemWrite = 1'b0;
    rd(32'h10, v0); check("ram_load", v0, 32'hAABBCCDD);
    rd(32'h13, v0); check("ram_low_bits_ignored", v0, 32'hAABBCCDD);
    rd(TXA, v0); check("txdata_reads_0", v0, 32'd0);
    rd(32'hFFFF000C, v0); check("unmapped_read", v0, 32'd0);

    // Push three bytes, then drain
    wr(TXA, 32'h41);
    check("push_latency_valid", {31'd0, bus.tx_valid}, 32'd1);
    wr(TXA, 32'h42); wr(TXA, 32'h43);
    rd(STA, v0); check("status_cnt3", v0, 32'h003);
    check("head_41", {24'd0, bus.tx_data}, 32'h41);
    bus.tx_ready = 1'b1;
    @(negedge clk); check("head_42", {24'd0, bus.tx_data}, 32'h42);
    @(negedge clk); check("head_43", {24'd0, bus.tx_data}, 32'h43);
    @(negedge clk); check("drained_valid", {31'd0, bus.tx_valid}, 32'd0);
    bus.tx_ready = 1'b0;
    rd(STA, v0); check("status_empty", v0, 32'h200);

    // Fill, overflow, W1C
    for (int i = 0; i < 8; i++) wr(TXA, 32'h10 + 32'(i));
    rd(STA, v0); check("status_full", v0, 32'h108);
    wr(TXA, 32'h55);
    rd(STA, v0); check("status_overflow", v0, 32'h508);
    wr(STA, 32'h400);
    rd(STA, v0); check("status_w1c", v0, 32'h108);

    // Push and pop in the same cycle while full
    bus.tx_ready = 1'b1;
    wr(TXA, 32'h66);
    bus.tx_ready = 1'b0;
    rd(STA, v0); check("full_push_pop_status", v0, 32'h108);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("drain_%0d", i), {24'd0, bus.tx_data},
               (i == 7) ? 32'h66 : 32'h11 + 32'(i));
      @(negedge clk);
    end
    check("drain_done", {31'd0, bus.tx_valid}, 32'd0);
    bus.tx_ready = 1'b0;

    // CYCLES delta, write ignored, wrap
    rd(CYA, v0);
    wr(CYA, 32'h0);
    repeat (4) @(negedge clk);
    rd(CYA, v1); check("cycles_delta5", v1 - v0, 32'd5);
    force dut.r_cycles = 32'hFFFFFFFF;
    rd(CYA, v0); check("cycles_forced", v0, 32'hFFFFFFFF);
    release dut.r_cycles;
    @(negedge clk);
    rd(CYA, v0); check("cycles_wrap", v0, 32'd0);

    // Out-of-range store
    wr(32'h0, 32'h12345678);
    wr(32'h400, 32'hDEADBEEF);
    rd(32'h0, v0);
    rd(STA, v1);
`ifdef ARM_DMEM_BOUNDS_EN
    check("bounds_ram0", v0, 32'h12345678);
    check("bounds_status", v1, 32'hA00);
    wr(STA, 32'h800);
    rd(STA, v1); check("bounds_w1c", v1, 32'h200);
`else
    check("alias_ram0", v0, 32'hDEADBEEF);
    check("alias_status", v1, 32'h200);
`endif

    // Reset mid-stream
    wr(TXA, 32'h77); wr(TXA, 32'h78);
    check("pre_reset_valid", {31'd0, bus.tx_valid}, 32'd1);
    #2 reset = 1'b1;
    #1 check("reset_valid_drop", {31'd0, bus.tx_valid}, 32'd0);
    rd(STA, v0); check("reset_status", v0, 32'h200);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("post_reset_valid", {31'd0, bus.tx_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
